// File: rtl/axi_stream_to_data.sv
// ---------------------------------------------------------------------------
// axi_stream_to_data
//
// AXI-Stream receiver that buffers {tlast, tdata} beats in a circular FIFO
// and presents the head entry to a consumer in first-word fall-through form.
// Tracks occupancy, the number of complete frames held (tlast beats), and a
// sticky flag for pop attempts made while empty.
//
// Ports
//   clk             : rising-edge clock for all state
//   rst             : asynchronous active-high reset
//   S_AXIS_tvalid   : upstream beat valid
//   S_AXIS_tready   : buffer can accept a beat (not full, not in reset)
//   S_AXIS_tdata    : beat payload, DATA_WIDTH bits
//   S_AXIS_tlast    : beat closes a frame
//   read_enable     : consumer pops the head entry
//   data_pkt        : head entry payload
//   data_tlast      : head entry tlast
//   data_valid      : head entry present
//   item_count      : beats currently stored
//   frame_available : at least one tlast beat is stored
//   rd_underflow    : sticky, set by a pop attempt while empty
// ---------------------------------------------------------------------------
module axi_stream_to_data #(
  parameter int DATA_WIDTH = 1024,
  parameter int FIFO_DEPTH = 32,
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  S_AXIS_tvalid,
  output logic                  S_AXIS_tready,
  input  logic [DATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                  S_AXIS_tlast,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] data_pkt,
  output logic                  data_tlast,
  output logic                  data_valid,
  output logic [CW-1:0]         item_count,
  output logic                  frame_available,
  output logic                  rd_underflow
);

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // Buffer memory holds data only; it is never reset, the pointers and
  // count decide which entries are meaningful.
  logic [DATA_WIDTH:0] mem_q [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] frames_q, frames_d;
  logic          underflow_q, underflow_d;

  logic push;
  logic pop;
  logic frame_in;
  logic frame_out;

  // tready is forced low during reset; otherwise it depends only on
  // occupancy, never on tvalid.
  assign S_AXIS_tready   = !rst && (count_q < DEPTH_C);
  assign data_valid      = (count_q != '0);
  assign {data_tlast, data_pkt} = mem_q[rd_ptr_q];
  assign item_count      = count_q;
  assign frame_available = (frames_q != '0);
  assign rd_underflow    = underflow_q;

  assign push      = S_AXIS_tvalid && S_AXIS_tready;
  assign pop       = read_enable && data_valid;
  assign frame_in  = push && S_AXIS_tlast;
  assign frame_out = pop && data_tlast;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    frames_d    = frames_q;
    underflow_d = underflow_q;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case ({frame_in, frame_out})
      2'b10:   frames_d = frames_q + 1'b1;
      2'b01:   frames_d = frames_q - 1'b1;
      default: frames_d = frames_q;
    endcase

    if (read_enable && !data_valid) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frames_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frames_q    <= frames_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {S_AXIS_tlast, S_AXIS_tdata};
  end

endmodule

// File: tb/tb_axi_stream_to_data.sv
// ---------------------------------------------------------------------------
// tb_axi_stream_to_data
//
// Directed bench for axi_stream_to_data (DATA_WIDTH=32, FIFO_DEPTH=32).
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_axi_stream_to_data;

  localparam int DW = 32;
  localparam int DEPTH = 32;

  logic          clk;
  logic          rst;
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tlast;
  logic          rd_en;
  logic [DW-1:0] data_pkt;
  logic          data_tlast;
  logic          data_valid;
  logic [5:0]    item_count;
  logic          frame_available;
  logic          rd_underflow;

  int n_tests;
  int n_fail;

  axi_stream_to_data #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .S_AXIS_tvalid  (tvalid),
    .S_AXIS_tready  (tready),
    .S_AXIS_tdata   (tdata),
    .S_AXIS_tlast   (tlast),
    .read_enable    (rd_en),
    .data_pkt       (data_pkt),
    .data_tlast     (data_tlast),
    .data_valid     (data_valid),
    .item_count     (item_count),
    .frame_available(frame_available),
    .rd_underflow   (rd_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [31:0] d, input logic l);
    tvalid = 1'b1; tdata = d; tlast = l; rd_en = 1'b0;
    step();
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic pop_beat();
    rd_en = 1'b1; tvalid = 1'b0;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; tvalid = 1'b0; tdata = '0; tlast = 1'b0; rd_en = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_tready", 32'(tready), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_count", 32'(item_count), 32'd0);
    chk("rst_frame", 32'(frame_available), 32'd0);
    chk("rst_uflow", 32'(rd_underflow), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_tready", 32'(tready), 32'd1);
    step();
    chk("rel_tready_edge", 32'(tready), 32'd1);

    // Single beat
    push_beat(32'hA5, 1'b1);
    chk("sb_valid", 32'(data_valid), 32'd1);
    chk("sb_pkt", data_pkt, 32'hA5);
    chk("sb_tlast", 32'(data_tlast), 32'd1);
    chk("sb_frame", 32'(frame_available), 32'd1);
    chk("sb_count", 32'(item_count), 32'd1);
    pop_beat();
    chk("sb_pop_valid", 32'(data_valid), 32'd0);
    chk("sb_pop_frame", 32'(frame_available), 32'd0);
    chk("sb_pop_count", 32'(item_count), 32'd0);

    // Fill to full, overflow beat held, one pop, then drain in order
    for (int i = 0; i < DEPTH; i++) push_beat(32'h100 + 32'(i), 1'b0);
    chk("full_count", 32'(item_count), 32'd32);
    chk("full_tready", 32'(tready), 32'd0);
    tvalid = 1'b1; tdata = 32'h133; tlast = 1'b0;
    step();
    step();
    chk("full_hold_count", 32'(item_count), 32'd32);
    chk("full_head", data_pkt, 32'h100);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("full_pop_count", 32'(item_count), 32'd31);
    chk("full_pop_tready", 32'(tready), 32'd1);
    step();
    tvalid = 1'b0;
    chk("full_refill_count", 32'(item_count), 32'd32);
    for (int i = 1; i < DEPTH; i++) begin
      chk("drain_data", data_pkt, 32'h100 + 32'(i));
      pop_beat();
    end
    chk("drain_33rd", data_pkt, 32'h133);
    pop_beat();
    chk("drain_empty", 32'(item_count), 32'd0);

    // Concurrent accept+pop at occupancy 5 across pointer wraps
    for (int i = 0; i < 5; i++) push_beat(32'h200 + 32'(i), 1'b0);
    for (int i = 0; i < 100; i++) begin
      chk("conc_data", data_pkt, 32'h200 + 32'(i));
      tvalid = 1'b1; tdata = 32'h205 + 32'(i); tlast = 1'b0; rd_en = 1'b1;
      step();
      chk("conc_count", 32'(item_count), 32'd5);
    end
    tvalid = 1'b0; rd_en = 1'b0;
    for (int i = 100; i < 105; i++) begin
      chk("conc_tail", data_pkt, 32'h200 + 32'(i));
      pop_beat();
    end
    chk("conc_empty", 32'(item_count), 32'd0);

    // Frames: 3-beat and 2-beat
    push_beat(32'h31, 1'b0);
    push_beat(32'h32, 1'b0);
    push_beat(32'h33, 1'b1);
    push_beat(32'h21, 1'b0);
    push_beat(32'h22, 1'b1);
    chk("fr_avail", 32'(frame_available), 32'd1);
    chk("fr_count", 32'(item_count), 32'd5);
    pop_beat();
    pop_beat();
    chk("fr_last1_tlast", 32'(data_tlast), 32'd1);
    pop_beat();
    chk("fr_after_first", 32'(frame_available), 32'd1);
    pop_beat();
    pop_beat();
    chk("fr_after_second", 32'(frame_available), 32'd0);

    // Underflow
    chk("uf_before", 32'(rd_underflow), 32'd0);
    pop_beat();
    chk("uf_set", 32'(rd_underflow), 32'd1);
    chk("uf_count", 32'(item_count), 32'd0);
    push_beat(32'h77, 1'b0);
    pop_beat();
    chk("uf_sticky", 32'(rd_underflow), 32'd1);
    chk("uf_sticky_count", 32'(item_count), 32'd0);

    // Asynchronous reset with 10 beats stored
    for (int i = 0; i < 10; i++) push_beat(32'h400 + 32'(i), (i % 3) == 2);
    chk("ar_pre_count", 32'(item_count), 32'd10);
    chk("ar_pre_frame", 32'(frame_available), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_count", 32'(item_count), 32'd0);
    chk("ar_valid", 32'(data_valid), 32'd0);
    chk("ar_frame", 32'(frame_available), 32'd0);
    chk("ar_tready", 32'(tready), 32'd0);
    chk("ar_uflow", 32'(rd_underflow), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("ar_rel_tready", 32'(tready), 32'd1);
    chk("ar_rel_count", 32'(item_count), 32'd0);
    push_beat(32'h5A, 1'b0);
    chk("ar_post_pkt", data_pkt, 32'h5A);
    chk("ar_post_count", 32'(item_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_stream_to_data.md
AXI_STREAM_TO_DATA -- requirements
Module: axi_stream_to_data

Interface
- REQ-001 The block SHALL have parameter DATA_WIDTH, default 1024, meaning the width of the stream data and of data_pkt.
- REQ-002 The block SHALL have parameter FIFO_DEPTH, default 32, meaning the number of buffered beats; power of two, minimum 2.
- REQ-003 The block SHALL use one clock, clk, and an asynchronous, active-high reset, rst.
- REQ-004 Port clk: input, 1 bit, rising-edge clock for all state.
- REQ-005 Port rst: input, 1 bit, asynchronous active-high reset.
- REQ-006 Port S_AXIS_tvalid: input, 1 bit, upstream beat valid.
- REQ-007 Port S_AXIS_tready: output, 1 bit, block can accept a beat.
- REQ-008 Port S_AXIS_tdata: input, DATA_WIDTH bits, beat payload.
- REQ-009 Port S_AXIS_tlast: input, 1 bit, last beat of a frame.
- REQ-010 Port read_enable: input, 1 bit, consumer pops the head entry.
- REQ-011 Port data_pkt: output, DATA_WIDTH bits, head entry payload (first-word fall-through).
- REQ-012 Port data_tlast: output, 1 bit, head entry tlast.
- REQ-013 Port data_valid: output, 1 bit, head entry present (FIFO not empty).
- REQ-014 Port item_count: output, clog2(FIFO_DEPTH)+1 bits, beats currently stored.
- REQ-015 Port frame_available: output, 1 bit, at least one complete frame (a tlast beat) is stored.
- REQ-016 Port rd_underflow: output, 1 bit, sticky flag set by a pop attempt while empty.

Function
- REQ-017 The block SHALL be a stream receiver that stores {tlast, tdata} beats in an internal circular buffer of FIFO_DEPTH entries, using wrapping write and read pointers.
- REQ-018 S_AXIS_tready SHALL equal (item_count < FIFO_DEPTH), combinationally, with no dependence on S_AXIS_tvalid.
- REQ-019 A beat SHALL be accepted on a rising edge where S_AXIS_tvalid and S_AXIS_tready are both 1; the block writes it at the write pointer, and the write pointer advances modulo FIFO_DEPTH.
- REQ-020 data_valid SHALL equal (item_count != 0); data_pkt and data_tlast SHALL present the entry at the read pointer; their values SHALL be don't-care while data_valid is 0.
- REQ-021 A pop SHALL occur on a rising edge where read_enable and data_valid are both 1; the read pointer advances modulo FIFO_DEPTH.
- REQ-022 read_enable while data_valid is 0 SHALL change no pointer or count and SHALL set rd_underflow to 1 on that edge.
- REQ-023 Latency SHALL be 1 cycle: a beat accepted at edge N is visible on data_pkt with data_valid=1 after edge N when the FIFO was empty.
- REQ-024 A simultaneous accept and pop SHALL leave item_count unchanged and SHALL be legal at any non-full, non-empty occupancy, and also when empty-to-1 is not implied (a pop needs data_valid).
- REQ-025 item_count SHALL increment on accept-only, decrement on pop-only, and never exceed FIFO_DEPTH or go below 0.
- REQ-026 An internal frame counter, width clog2(FIFO_DEPTH)+1, SHALL increment on an accepted beat with tlast=1 and decrement on a popped beat with data_tlast=1; both in one cycle SHALL leave it unchanged.
- REQ-027 frame_available SHALL equal (frame counter != 0).
- REQ-028 When full, S_AXIS_tready SHALL be 0 and no beat is lost; a pop at full SHALL raise S_AXIS_tready in the following cycle.
- REQ-029 Upstream data presented while S_AXIS_tready is 0 SHALL NOT be written.

Reset
- REQ-030 Asserting rst SHALL immediately clear both pointers, item_count, the frame counter and rd_underflow to 0, independent of clk.
- REQ-031 While rst is 1, S_AXIS_tready SHALL be 0 and data_valid SHALL be 0; after deassertion, S_AXIS_tready SHALL be 1 at the first rising edge.
- REQ-032 Reset asserted mid-frame SHALL discard all stored beats; the buffer memory contents need no reset.
- REQ-033 rd_underflow SHALL be cleared only by rst.

Verification
- REQ-034 Single beat: tdata=0xA5, tlast=1, accepted at edge N -> after N: data_valid=1, data_pkt=0xA5, data_tlast=1, frame_available=1, item_count=1; pop -> all return to 0.
- REQ-035 Fill: 32 beats with no pops -> item_count=32, S_AXIS_tready=0; a 33rd beat held valid is not written; one pop -> tready=1 next cycle, and the 33rd beat is then accepted in order.
- REQ-036 Concurrent: accept and pop each cycle for 100 cycles at occupancy 5 -> item_count stays 5; the output sequence equals the input sequence across pointer wrap.
- REQ-037 Frames: a 3-beat and a 2-beat frame are buffered -> frame counter reaches 2; popping the first tlast beat -> frame_available stays 1; popping the second -> 0.
- REQ-038 Underflow: read_enable=1 while empty -> rd_underflow=1, which persists after later traffic; item_count stays 0.
- REQ-039 Reset mid-operation: rst asserted asynchronously with 10 beats stored -> item_count=0, data_valid=0, frame_available=0 without a clock edge; S_AXIS_tready returns to 1 after release.
